// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (FSM encoding, defaults, frame constants).
// Parity option selected by macro UART_TX_PARITY_EN.
package uart_pkg;

  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int BAUD_DEF     = 9600;
  localparam int DATA_BITS    = 8;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } tx_state_e;
`else
  localparam int FRAME_BITS = 10;
  typedef enum logic [1:0] {
    ST_IDLE, ST_START, ST_DATA, ST_STOP
  } tx_state_e;
`endif

  // Clock cycles per bit, truncating division.
  function automatic int calc_baud_cnt(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock byte FIFO with first-word-fall-through read.
// Writes are refused while full, even when a read happens on the same edge.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         s_clk,
  input  logic         s_rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;

  assign full    = (r_count == CW'(DEPTH));
  assign empty   = (r_count == '0);
  assign w_push  = wr_en && !full;
  assign w_pop   = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge s_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter, 8N1 (8E1 with UART_TX_PARITY_EN).
// Queued frames go out back-to-back with no idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_DEF,
  parameter int BAUD       = BAUD_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       s_clk,
  input  logic       s_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_flag,
  output logic       data_out,
  output logic       tx_busy,
  output logic       tx_full,
  output logic       tx_ovf
);

  localparam int BAUD_CNT = calc_baud_cnt(CLK_FREQ, BAUD);
  localparam int BCW      = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
  localparam logic [BCW-1:0] BC_LAST  = BCW'(BAUD_CNT - 1);
  localparam logic [3:0]     BIT_LAST = 4'(DATA_BITS - 1);

  tx_state_e      r_state, w_state_nxt;
  logic [BCW-1:0] r_baud, w_baud_nxt;
  logic [3:0]     r_bit, w_bit_nxt;
  logic [7:0]     r_shift, w_shift_nxt;
  logic           r_data_out, w_out_nxt;
  logic           r_ovf;
  logic           w_pop, w_empty, w_full, w_bit_end;
  logic [7:0]     w_rd_data;
`ifdef UART_TX_PARITY_EN
  logic           r_par, w_par_nxt;
`endif

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .s_clk   (s_clk),
    .s_rst   (s_rst),
    .wr_en   (tx_flag),
    .wr_data (tx_data),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign w_bit_end = (r_baud == BC_LAST);
  assign data_out  = r_data_out;
  assign tx_busy   = (r_state != ST_IDLE);
  assign tx_full   = w_full;
  assign tx_ovf    = r_ovf;

  // State, counters, shift register and registered line output.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      r_state    <= ST_IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_data_out <= 1'b1;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud     <= w_baud_nxt;
      r_bit      <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_data_out <= w_out_nxt;
      r_ovf      <= tx_flag && w_full;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity latched at pop, since the shift register is consumed.
  always_ff @(posedge s_clk) begin
    if (s_rst) r_par <= 1'b0;
    else       r_par <= w_par_nxt;
  end
`endif

  // Next-state logic; the line value is derived from the next state so the
  // output register switches on the same edge as the state.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = (r_state == ST_IDLE) ? '0 : r_baud + BCW'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_START;
          w_bit_nxt   = '0;
          w_shift_nxt = w_rd_data;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
          w_baud_nxt  = '0;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_shift_nxt = r_shift >> 1;
          w_bit_nxt   = r_bit + 4'd1;
          if (r_bit == BIT_LAST) begin
            w_bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = ST_STOP;
          w_baud_nxt  = '0;
        end
      end
`endif
      ST_STOP: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_START;
            w_shift_nxt = w_rd_data;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
`ifdef UART_TX_PARITY_EN
    if (w_pop) w_par_nxt = ^w_rd_data;
`endif
  end

  // Line value for the upcoming state.
  always_comb begin
    w_out_nxt = 1'b1;
    case (w_state_nxt)
      ST_START:  w_out_nxt = 1'b0;
      ST_DATA:   w_out_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_out_nxt = r_par;
`endif
      default:   w_out_nxt = 1'b1;
    endcase
`ifdef UART_TX_PARITY_EN
    if (w_state_nxt == ST_PARITY && r_state != ST_PARITY) w_out_nxt = w_par_nxt;
`endif
  end

endmodule
